uart_word_loader: RTL and testbench
===================================

// Module: uart_word_loader
// PURPOSE
//  Parametrised UART program loader: receives 8N1 serial bytes, packs them little-endian into words,
//  and emits one write per word into a word-addressed memory (e.g. instruction RAM) until DEPTH words are written.
//  Sits between the uart_rxd pin and the memory write port; done releases processor reset.
//  Adds mid-bit sampling, framing-error detection, false-start rejection, and optional checksum.
// PARAMETERS
//  CLKS_PER_BIT  50   clk cycles per UART bit; must be >= 4
//  WORD_BYTES    4    bytes per word; wr_data width is 8*WORD_BYTES
//  DEPTH         512  number of words to load before done
//  ADDR_W        9    wr_addr width; must satisfy 2**ADDR_W >= DEPTH
//  SYNC_STAGES   2    flops in the rxd synchroniser; must be >= 2
// PORTS
//  clk        in   1             system clock
//  rst        in   1             synchronous reset, active-high
//  rxd        in   1             UART line, idle high, async
//  wr_en      out  1             one-cycle write strobe
//  wr_addr    out  ADDR_W        word address, 0..DEPTH-1
//  wr_data    out  8*WORD_BYTES  assembled word, first byte in [7:0]
//  done       out  1             sticky: load complete
//  frame_err  out  1             one-cycle pulse: bad stop bit
//  err_cnt    out  8             framing errors, saturates at 255
//  csum_ok    out  1             checksum matched; only with macro, else 0
// BEHAVIOUR
//  Reset values: all outputs 0. Reset also clears state, word counter, byte index, shift register and sum.
//  Reset takes effect mid-frame: no wr_en is produced for the partial frame.
//  rxd passes through the SYNC_STAGES synchroniser; all logic uses the synchronised value rxs.
//  Bit FSM:
//   IDLE:  on rxs==0 -> START, load bit timer.
//   START: at CLKS_PER_BIT/2 cycles, resample. If rxs==1 (false start) -> IDLE; else -> DATA.
//   DATA:  sample every CLKS_PER_BIT cycles; 8 bits, LSB first -> STOP.
//   STOP:  sample once. rxs==1 -> byte_valid pulse; rxs==0 -> frame_err pulse, err_cnt++, byte dropped.
//          Either way -> IDLE.
//  A dropped byte does not advance the byte index.
//  Byte index cycles 0..WORD_BYTES-1. The word shifts as {byte, word[8*WORD_BYTES-1:8]}.
//  On the final byte's byte_valid, wr_en is asserted the next cycle.
//   During that cycle, wr_addr = word counter and wr_data = the word.
//   The counter increments after the write; wr_addr/wr_data hold until the next write.
//  When the counter reaches DEPTH, done=1 the cycle after the last wr_en.
//   After done, bytes are still received (frame_err still reported) but never written.
//  A new start bit is accepted in the cycle the FSM returns to IDLE. Back-to-back frames are supported.
// CONFIGURATION
//  UART_LOADER_CSUM_EN defined:
//   A 32-bit modular sum of the low 32 bits of every written word is kept.
//   After DEPTH words, one extra word is received and not written.
//   done rises the cycle after that extra word completes.
//   csum_ok=1 iff the extra word equals the sum; csum_ok is sticky until rst.
//  Macro undefined: no adder, csum_ok tied 0, done as described above.
// STRUCTURE
//  Package uart_loader_pkg holds:
//   - the bit-FSM state typedef: IDLE, START, DATA, STOP;
//   - the BITS_PER_BYTE=8 constant;
//   - the ERR_CNT_W=8 constant.
//  One sub-module, uart_rx_core: synchroniser, bit FSM and timer.
//   Outputs byte[7:0], byte_valid and frame_err.
//  Word packing, address counter, done and checksum stay in uart_word_loader.
// TESTING (CLKS_PER_BIT=8, DEPTH=4 unless stated)
//  1. Bytes 78,56,34,12 -> one wr_en, wr_addr=0, wr_data=32'h12345678, done=0.
//  2. rxd low for 2 cycles then high -> no byte_valid, no frame_err; FSM returns to IDLE.
//     A following clean frame is received correctly.
//  3. Frame 0xAA with stop bit 0 -> frame_err pulse, err_cnt=1, no index advance.
//     Next 4 good bytes form word 0.
//  4. 4 words sent -> wr_addr 0,1,2,3 and done=1 after the 4th write.
//     A 5th word produces no wr_en; done stays 1.
//  5. rst asserted mid-DATA of byte 2 -> all outputs 0.
//     The next 4 good bytes write wr_addr=0 with the correct data.
//  6. With UART_LOADER_CSUM_EN: words 1,2,3,4 then 10 -> csum_ok=1, done=1, only 4 wr_en.
//     Repeat with 11 as the final word -> csum_ok=0, done=1.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared receiver state encoding and widths for the UART word loader
package uart_loader_pkg;
    typedef logic [1:0] rx_state_t;
    localparam rx_state_t IDLE  = 2'd0;
    localparam rx_state_t START = 2'd1;
    localparam rx_state_t DATA  = 2'd2;
    localparam rx_state_t STOP  = 2'd3;
    localparam int BITS_PER_BYTE = 8;
    localparam int ERR_CNT_W = 8;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: rxd synchroniser and mid-bit sampling 8N1 byte receiver
module uart_rx_core
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    rx_state_t              state;
    logic [TW-1:0]          tmr;
    logic [2:0]             bit_idx;
    assign rxs = sync[SYNC_STAGES-1];
    // synchroniser resets to idle-high so reset release never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= '1;
            state      <= IDLE;
            tmr        <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], rxd};
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            tmr        <= tmr + 1'b1;
            case (state)
                IDLE: if (!rxs) begin
                    state <= START;
                    tmr   <= '0;
                end
                START: if (tmr == HALF) begin
                    state   <= rxs ? IDLE : DATA;
                    tmr     <= '0;
                    bit_idx <= '0;
                end
                DATA: if (tmr == FULL) begin
                    rx_byte <= {rxs, rx_byte[7:1]};
                    tmr     <= '0;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'(BITS_PER_BYTE - 1)) state <= STOP;
                end
                default: if (tmr == FULL) begin
                    byte_valid <= rxs;
                    frame_err  <= !rxs;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_word_loader.sv
// uart_word_loader: packs UART bytes into words for a memory write port; UART_LOADER_CSUM_EN adds a trailing checksum word
module uart_word_loader
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50,
    parameter int WORD_BYTES   = 4,
    parameter int DEPTH        = 512,
    parameter int ADDR_W       = 9,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rxd,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic                    done,
    output logic                    frame_err,
    output logic [ERR_CNT_W-1:0]    err_cnt,
    output logic                    csum_ok
);
    localparam int W     = 8 * WORD_BYTES;
    localparam int BI_W  = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic [BI_W-1:0]  byte_idx;
    logic [W-1:0]     sh;
    logic [W-1:0]     word;
    logic [CNT_W-1:0] wcnt;
    logic             last_byte;
    logic             full;
    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );
    assign word      = (W'(rx_byte) << (W - 8)) | (sh >> 8);
    assign last_byte = byte_valid && byte_idx == BI_W'(WORD_BYTES - 1);
    assign full      = wcnt == CNT_W'(DEPTH);
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx <= '0;
            sh       <= '0;
            wcnt     <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err_cnt  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (byte_valid) begin
                sh       <= word;
                byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
            end
            if (last_byte && !full) begin
                wr_en   <= 1'b1;
                wr_addr <= ADDR_W'(wcnt);
                wr_data <= word;
                wcnt    <= wcnt + 1'b1;
            end
            if (frame_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end
`ifdef UART_LOADER_CSUM_EN
    logic [31:0] sum;
    // the word completing after the memory is full is the checksum, never written
    always_ff @(posedge clk) begin
        if (rst) begin
            sum     <= '0;
            done    <= 1'b0;
            csum_ok <= 1'b0;
        end else begin
            if (last_byte && !full) sum <= sum + 32'(word);
            if (last_byte && full && !done) begin
                done    <= 1'b1;
                csum_ok <= 32'(word) == sum;
            end
        end
    end
`else
    assign csum_ok = 1'b0;
    always_ff @(posedge clk) begin
        if (rst) done <= 1'b0;
        else if (wr_en && full) done <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: randomized UART frames checked against a byte/word level loader model
module tb_uart_word_loader;
    localparam int CPB   = 8;
    localparam int WB    = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef UART_LOADER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          done;
    logic          frame_err;
    logic [7:0]    err_cnt;
    logic          csum_ok;
    int total = 0;
    int bad   = 0;
    logic [AW+31:0] exp_q[$];
    logic [7:0]     acc[$];
    int             words_m, bad_m, fe_seen;
    bit             done_m, csum_m, done_next;
    logic [31:0]    sum_m;

    uart_word_loader #(
        .CLKS_PER_BIT(CPB),
        .WORD_BYTES  (WB),
        .DEPTH       (DEPTH),
        .ADDR_W      (AW),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .done     (done),
        .frame_err(frame_err),
        .err_cnt  (err_cnt),
        .csum_ok  (csum_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic on_word(input logic [31:0] w);
        if (words_m < DEPTH) begin
            exp_q.push_back({AW'(words_m), w});
            words_m++;
            sum_m += w;
            if (!CSUM && words_m == DEPTH) done_m = 1'b1;
        end else if (CSUM && !done_m) begin
            done_m = 1'b1;
            csum_m = (w == sum_m);
        end
    endtask

    // model is updated before the frame goes out, so it is ready when wr_en appears
    task automatic send_byte(input logic [7:0] b, input bit good);
        logic [9:0] f;
        if (good) begin
            acc.push_back(b);
            if (acc.size() == WB) begin
                on_word({acc[3], acc[2], acc[1], acc[0]});
                acc.delete();
            end
        end else bad_m++;
        f = {good, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (CPB) @(negedge clk);
        end
        if (!good) begin
            rxd = 1'b1;
            repeat (2 * CPB) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < WB; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.delete();
        acc.delete();
        words_m = 0; bad_m = 0; fe_seen = 0; sum_m = '0;
        done_m = 1'b0; csum_m = 1'b0; done_next = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", 64'(wr_en), 0);
        chk("rst_wr_addr", 64'(wr_addr), 0);
        chk("rst_wr_data", 64'(wr_data), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_frame_err", 64'(frame_err), 0);
        chk("rst_err_cnt", 64'(err_cnt), 0);
        chk("rst_csum_ok", 64'(csum_ok), 0);
    endtask

    task automatic settle(input string tag);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk({tag, "_pending"}, 64'(exp_q.size()), 0);
        chk({tag, "_done"}, 64'(done), 64'(done_m));
        chk({tag, "_csum_ok"}, 64'(csum_ok), 64'(csum_m));
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(bad_m > 255 ? 255 : bad_m));
        chk({tag, "_fe_pulses"}, 64'(fe_seen), 64'(bad_m));
    endtask

    initial begin : monitor
        logic [AW+31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frame_err) fe_seen++;
                if (done_next) chk("done_after_last_wr", 64'(done), 1);
                done_next = 1'b0;
                if (wr_en) begin
                    chk("done_during_wr", 64'(done), 0);
                    if (exp_q.size() == 0) chk("unexpected_wr", 64'(wr_en), 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 64'(wr_addr), 64'(e[AW+31:32]));
                        chk("wr_data", 64'(wr_data), 64'(e[31:0]));
                        if (!CSUM && int'(e[AW+31:32]) == DEPTH - 1) done_next = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();
        foreach (acc[i]) acc[i] = '0;
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        settle("t1_word");

        do_reset();
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_word($urandom);
        settle("t2_false_start");

        do_reset();
        send_byte(8'hAA, 1'b0);
        send_word($urandom);
        settle("t3_frame_err");

        do_reset();
        for (int i = 0; i < DEPTH; i++) send_word($urandom);
        settle("t4_full");
        send_word($urandom);
        settle("t4_after_done");

        do_reset();
        send_word($urandom | 32'h1);
        send_byte($urandom, 1'b1);
        send_byte($urandom, 1'b1);
        rxd = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        do_reset();
        send_word($urandom);
        settle("t5_mid_reset");

        if (CSUM) begin
            do_reset();
            for (int i = 1; i <= 4; i++) send_word(32'(i));
            send_word(32'd10);
            settle("t6_csum_good");
            do_reset();
            for (int i = 1; i <= 4; i++) send_word(32'(i));
            send_word(32'd11);
            settle("t6_csum_bad");
        end

        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 24; i++) send_byte(8'($urandom), $urandom_range(0, 5) != 0);
            settle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
